depth_analysis_scheduler: RTL and testbench

- Shares one logic-depth analyzer datapath between NREQ requesters.
- Each requester submits a feature vector: signal_in, fan_in, fan_out, gate_count, path_length, num_ff.
- Round-robin grant. The block drives the analyzer inputs, holds them stable for a fixed analyzer latency, samples depth, then returns the result tagged with the requester ID.
- Sits between the feature-extraction front ends and the analyzer instance.

---
 rtl/depth_sched_pkg.sv | 26 ++
 rtl/depth_analysis_scheduler_rr_arbiter.sv | 35 +++
 rtl/depth_analysis_scheduler.sv | 120 ++++++++++++
 tb/tb_depth_analysis_scheduler.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/depth_sched_pkg.sv
// rtl/depth_sched_pkg.sv - shared types and field layout for the depth analysis scheduler
package depth_sched_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, DELIVER} state_t;

  localparam int FEAT_W = 8;
  localparam int VEC_W  = 48;

  localparam int OFF_NUM_FF      = 0;
  localparam int OFF_PATH_LENGTH = 8;
  localparam int OFF_GATE_COUNT  = 16;
  localparam int OFF_FAN_OUT     = 24;
  localparam int OFF_FAN_IN      = 32;
  localparam int OFF_SIGNAL_IN   = 40;

  // First member lands in the MSBs, matching the packed slot layout
  typedef struct packed {
    logic [FEAT_W-1:0] signal_in;
    logic [FEAT_W-1:0] fan_in;
    logic [FEAT_W-1:0] fan_out;
    logic [FEAT_W-1:0] gate_count;
    logic [FEAT_W-1:0] path_length;
    logic [FEAT_W-1:0] num_ff;
  } feat_vec_t;

endpackage

// File: rtl/depth_analysis_scheduler_rr_arbiter.sv
// rtl/depth_analysis_scheduler_rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 3
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id
);

  logic [IDW-1:0] lo_id;
  logic [IDW-1:0] hi_id;
  logic           hi_hit;

  // Lowest request at or above ptr wins; otherwise wrap to the lowest request overall
  always_comb begin
    lo_id  = '0;
    hi_id  = '0;
    hi_hit = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) lo_id = IDW'(i);
      if (req[i] && (IDW'(i) >= ptr)) begin
        hi_id  = IDW'(i);
        hi_hit = 1'b1;
      end
    end
    grant_id = hi_hit ? hi_id : lo_id;
    grant    = '0;
    for (int i = 0; i < NREQ; i++) begin
      grant[i] = (|req) && (IDW'(i) == grant_id);
    end
  end

endmodule

// File: rtl/depth_analysis_scheduler.sv
// rtl/depth_analysis_scheduler.sv - shares one depth analyzer among NREQ requesters; DEPTH_STATS_EN adds delivery statistics
module depth_analysis_scheduler
  import depth_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int ANA_LAT = 2,
  parameter int IDW     = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*VEC_W-1:0] req_vec,
  output logic [7:0]            ana_signal_in,
  output logic [7:0]            ana_fan_in,
  output logic [7:0]            ana_fan_out,
  output logic [7:0]            ana_gate_count,
  output logic [7:0]            ana_path_length,
  output logic [7:0]            ana_num_ff,
  input  logic [7:0]            ana_depth,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [IDW-1:0]        res_id,
  output logic [7:0]            res_depth,
`ifdef DEPTH_STATS_EN
  output logic [7:0]            depth_max,
  input  logic [7:0]            thresh,
  output logic [15:0]           over_cnt,
`endif
  output logic                  busy
);

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [3:0]     cnt;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0] grant_id;
  feat_vec_t      slot;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req      (req_valid),
    .ptr      (rr_ptr),
    .grant    (grant),
    .grant_id (grant_id)
  );

  always_comb begin
    slot = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == grant_id) slot = req_vec[i*VEC_W +: VEC_W];
    end
  end

  assign req_ready = (state == IDLE) ? grant : '0;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      cnt             <= '0;
      ana_signal_in   <= '0;
      ana_fan_in      <= '0;
      ana_fan_out     <= '0;
      ana_gate_count  <= '0;
      ana_path_length <= '0;
      ana_num_ff      <= '0;
      res_valid       <= 1'b0;
      res_id          <= '0;
      res_depth       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|grant) begin
            ana_signal_in   <= slot.signal_in;
            ana_fan_in      <= slot.fan_in;
            ana_fan_out     <= slot.fan_out;
            ana_gate_count  <= slot.gate_count;
            ana_path_length <= slot.path_length;
            ana_num_ff      <= slot.num_ff;
            res_id          <= grant_id;
            cnt             <= 4'(ANA_LAT - 1);
            state           <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            res_depth <= ana_depth;
            res_valid <= 1'b1;
            state     <= DELIVER;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DELIVER: begin
          // Pointer moves past the owner so it has lowest priority next round
          if (res_ready) begin
            res_valid <= 1'b0;
            rr_ptr    <= (res_id == IDW'(NREQ - 1)) ? '0 : res_id + 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DEPTH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth_max <= '0;
      over_cnt  <= '0;
    end else if (state == DELIVER && res_valid && res_ready) begin
      if (res_depth > depth_max) depth_max <= res_depth;
      if (res_depth > thresh && over_cnt != 16'hFFFF) over_cnt <= over_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_depth_analysis_scheduler.sv
// tb/tb_depth_analysis_scheduler.sv - directed self-checking bench for depth_analysis_scheduler
module tb_depth_analysis_scheduler;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [191:0] req_vec;
  logic [7:0]   ana_signal_in, ana_fan_in, ana_fan_out, ana_gate_count, ana_path_length, ana_num_ff;
  logic [7:0]   ana_depth;
  logic         res_valid;
  logic         res_ready;
  logic [2:0]   res_id;
  logic [7:0]   res_depth;
  logic         busy;
`ifdef DEPTH_STATS_EN
  logic [7:0]   depth_max;
  logic [7:0]   thresh;
  logic [15:0]  over_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int gcyc, prev;
  logic [47:0] vecs [4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Analyzer stand-in: depth = fan_in + gate_count + 1
  assign ana_depth = ana_fan_in + ana_gate_count + 8'd1;

  depth_analysis_scheduler #(.NREQ(4), .ANA_LAT(2), .IDW(3)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_vec         (req_vec),
    .ana_signal_in   (ana_signal_in),
    .ana_fan_in      (ana_fan_in),
    .ana_fan_out     (ana_fan_out),
    .ana_gate_count  (ana_gate_count),
    .ana_path_length (ana_path_length),
    .ana_num_ff      (ana_num_ff),
    .ana_depth       (ana_depth),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_id          (res_id),
    .res_depth       (res_depth),
`ifdef DEPTH_STATS_EN
    .depth_max       (depth_max),
    .thresh          (thresh),
    .over_cnt        (over_cnt),
`endif
    .busy            (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] mkvec(input logic [7:0] s, fi, fo, g, p, n);
    return {s, fi, fo, g, p, n};
  endfunction

  function automatic logic [7:0] exp_depth(input int id);
    case (id)
      0:       return 8'd9;
      1:       return 8'd19;
      2:       return 8'd36;
      default: return 8'd53;
    endcase
  endfunction

  task automatic load_vecs;
    req_vec = {vecs[3], vecs[2], vecs[1], vecs[0]};
  endtask

  task automatic wait_grant(input string tag);
    int t = 0;
    while (req_ready == 4'b0 && t < 20) begin
      @(negedge clk); #1; t++;
    end
    chk({tag, "_grant_timeout"}, 64'(req_ready != 4'b0), 64'd1);
  endtask

  task automatic wait_result(input string tag);
    int t = 0;
    while (res_valid !== 1'b1 && t < 20) begin
      @(negedge clk); #1; t++;
    end
    chk({tag, "_result_timeout"}, 64'(res_valid), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; res_ready = 1'b0; req_vec = '0;
`ifdef DEPTH_STATS_EN
    thresh = 8'd0;
`endif
    vecs[0] = mkvec(8'h01, 8'h03, 8'h02, 8'h05, 8'h04, 8'h01);
    vecs[1] = mkvec(8'h00, 8'd4,  8'h00, 8'd14, 8'h00, 8'h00);
    vecs[2] = mkvec(8'h00, 8'd10, 8'h00, 8'd25, 8'h00, 8'h00);
    vecs[3] = mkvec(8'h00, 8'd20, 8'h00, 8'd32, 8'h00, 8'h00);

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_res", 64'({res_id, res_depth}), 64'd0);
    chk("rst_ana", 64'({ana_signal_in, ana_fan_in, ana_fan_out, ana_gate_count, ana_path_length, ana_num_ff}), 64'd0);
    rst_n = 1'b1;

    // Single request
    @(negedge clk);
    load_vecs();
    req_valid = 4'b0001;
    #1;
    chk("single_ready", 64'(req_ready), 64'h1);
    chk("single_busy_idle", 64'(busy), 64'd0);
    gcyc = cyc;
    @(negedge clk); req_valid = '0; #1;
    chk("single_fan_in", 64'(ana_fan_in), 64'd3);
    chk("single_ana_all", 64'({ana_signal_in, ana_fan_in, ana_fan_out, ana_gate_count, ana_path_length, ana_num_ff}), 64'h010302050401);
    chk("single_busy_wait", 64'(busy), 64'd1);
    chk("single_ready_wait", 64'(req_ready), 64'h0);
    @(negedge clk); #1;
    chk("single_not_yet", 64'(res_valid), 64'd0);
    @(negedge clk); #1;
    chk("single_res_valid", 64'(res_valid), 64'd1);
    chk("single_latency", 64'(cyc - gcyc), 64'd3);
    chk("single_res_id", 64'(res_id), 64'd0);
    chk("single_res_depth", 64'(res_depth), 64'd9);
    res_ready = 1'b1;
    @(negedge clk); #1;
    chk("single_busy_after", 64'(busy), 64'd0);
    chk("single_valid_after", 64'(res_valid), 64'd0);
    chk("single_ana_hold", 64'(ana_fan_in), 64'd3);
    res_ready = 1'b0;

    // Round robin from a fresh pointer
    rst_n = 1'b0; #2; rst_n = 1'b1;
    req_valid = 4'b1111; res_ready = 1'b1;
    #1;
    prev = 0;
    for (int n = 0; n < 5; n++) begin
      wait_grant("rr");
      gcyc = cyc;
      chk("rr_grant", 64'(req_ready), 64'(1 << (n % 4)));
      if (n > 0) chk("rr_spacing", 64'(gcyc - prev), 64'd4);
      prev = gcyc;
      @(negedge clk); #1;
      wait_result("rr");
      chk("rr_id", 64'(res_id), 64'(n % 4));
      chk("rr_depth", 64'(res_depth), 64'(exp_depth(n % 4)));
      @(negedge clk); #1;
    end
    req_valid = '0; res_ready = 1'b0;

    // Backpressure with rr_ptr=1
    @(negedge clk);
    req_valid = 4'b0010;
    #1;
    wait_grant("bp");
    chk("bp_grant", 64'(req_ready), 64'h2);
    @(negedge clk); req_valid = 4'b1111; #1;
    wait_result("bp");
    for (int k = 0; k < 10; k++) begin
      chk("bp_hold", 64'({res_valid, res_id, res_depth, req_ready, busy}), 64'({1'b1, 3'd1, 8'd19, 4'b0000, 1'b1}));
      @(negedge clk); #1;
    end
    res_ready = 1'b1;
    @(negedge clk); #1;
    chk("bp_release_valid", 64'(res_valid), 64'd0);
    chk("bp_next_grant", 64'(req_ready), 64'h4);
    req_valid = 4'b0100;
    @(negedge clk); #1;
    wait_result("bp2");
    chk("bp2_id", 64'(res_id), 64'd2);
    chk("bp2_depth", 64'(res_depth), 64'd36);
    @(negedge clk); req_valid = '0; #1;

    // Skip and wrap: rr_ptr=3, requests 0 and 2
    @(negedge clk);
    req_valid = 4'b0101;
    #1;
    chk("wrap_grant0", 64'(req_ready), 64'h1);
    @(negedge clk); #1;
    wait_result("wrap");
    chk("wrap_id", 64'(res_id), 64'd0);
    chk("wrap_depth", 64'(res_depth), 64'd9);
    @(negedge clk); #1;
    chk("skip_next2", 64'(req_ready), 64'h4);
    @(negedge clk); #1;
    chk("mid_busy", 64'(busy), 64'd1);

    // Reset during WAIT
    rst_n = 1'b0; req_valid = '0;
    #1;
    chk("async_outs", 64'({res_valid, res_id, res_depth, busy, req_ready}), 64'd0);
    chk("async_ana", 64'({ana_signal_in, ana_fan_in, ana_fan_out, ana_gate_count, ana_path_length, ana_num_ff}), 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      chk("post_rst_quiet", 64'({res_valid, busy}), 64'd0);
    end
    req_valid = 4'b1010;
    #1;
    chk("post_rst_grant", 64'(req_ready), 64'h2);
    res_ready = 1'b1;
    @(negedge clk); req_valid = '0; #1;
    wait_result("post_rst");
    chk("post_rst_id", 64'(res_id), 64'd1);
    chk("post_rst_depth", 64'(res_depth), 64'd19);
    @(negedge clk); #1;

`ifdef DEPTH_STATS_EN
    rst_n = 1'b0; #2; rst_n = 1'b1;
    thresh = 8'd8;
    chk("stats_rst", 64'({depth_max, over_cnt}), 64'd0);
    foreach (vecs[j]) begin
      logic [7:0] d;
      case (j)
        0:       d = 8'd5;
        1:       d = 8'd12;
        2:       d = 8'd9;
        default: d = 8'd3;
      endcase
      @(negedge clk);
      vecs[0] = mkvec(8'h00, d - 8'd1, 8'h00, 8'h00, 8'h00, 8'h00);
      load_vecs();
      req_valid = 4'b0001;
      #1;
      wait_grant("stats");
      @(negedge clk); req_valid = '0; #1;
      wait_result("stats");
      chk("stats_depth", 64'(res_depth), 64'(d));
      @(negedge clk); #1;
    end
    chk("stats_depth_max", 64'(depth_max), 64'd12);
    chk("stats_over_cnt", 64'(over_cnt), 64'd2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
